// File: rtl/conv_wide_narrow_hs.sv
// Wide-to-narrow serialiser: one IN_W word in, N = IN_W/OUT_W lanes out, with
// valid/ready handshakes on both sides and a synchronous flush.
module conv_wide_narrow_hs #(
    parameter int unsigned IN_W      = 32,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [IN_W-1:0]                   data_in,
    input  logic                              valid_in,
    output logic                              ready_in,
    output logic [OUT_W-1:0]                  data_out,
    output logic                              valid_out,
    input  logic                              ready_out,
    output logic [$clog2(IN_W/OUT_W)-1:0]     lane_idx,
    output logic                              last_out
);

    localparam int unsigned N  = IN_W / OUT_W;
    localparam int unsigned LW = $clog2(N);
    localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

    generate
        if ((IN_W % OUT_W) != 0 || N < 2) begin : g_bad_ratio
            $error("conv_wide_narrow_hs: IN_W must be a multiple of OUT_W with at least two lanes");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t            r_state;
    logic [LW-1:0]     r_lane;
    logic [IN_W-1:0]   r_hold;
    logic [IN_W-1:0]   w_ordered;
    logic              w_lane_last;
    logic              w_busy;
    logic              w_acc_in;
    logic              w_acc_out;

    // Lanes are reordered at capture so lane 0 always sits in the low bits and
    // the word simply shifts down by OUT_W per emitted lane.
    always_comb begin
        w_ordered = data_in;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < N; i++) begin
                w_ordered[i*OUT_W +: OUT_W] = data_in[(N-1-i)*OUT_W +: OUT_W];
            end
        end
    end

    assign w_busy      = (r_state == S_BUSY);
    assign w_lane_last = (r_lane == LAST_LANE);
    assign ready_in    = !reset && !flush && (!w_busy || (w_lane_last && ready_out));
    assign w_acc_in    = valid_in && ready_in;
    assign w_acc_out   = w_busy && ready_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_hold  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
        end else if (!w_busy) begin
            if (w_acc_in) begin
                r_hold  <= w_ordered;
                r_lane  <= '0;
                r_state <= S_BUSY;
            end
        end else if (w_acc_out) begin
            if (!w_lane_last) begin
                r_lane <= r_lane + LW'(1);
                r_hold <= r_hold >> OUT_W;
            end else if (w_acc_in) begin
                r_hold <= w_ordered;
                r_lane <= '0;
            end else begin
                r_state <= S_IDLE;
                r_lane  <= '0;
            end
        end
    end

    assign valid_out = w_busy;
    assign data_out  = w_busy ? r_hold[OUT_W-1:0] : '0;
    assign lane_idx  = r_lane;
    assign last_out  = w_busy && w_lane_last;

endmodule

// File: tb/tb_conv_wide_narrow_hs.sv
// Directed bench for conv_wide_narrow_hs: MSB-first 32/8, LSB-first 32/8 and
// a 48/16 instance, each step checked with hand-computed expectations.
module tb_conv_wide_narrow_hs;

    logic clk;
    logic reset;

    logic        m_flush, m_vin, m_rin, m_vout, m_rout, m_last;
    logic [31:0] m_din;
    logic [7:0]  m_dout;
    logic [1:0]  m_idx;

    logic        l_flush, l_vin, l_rin, l_vout, l_rout, l_last;
    logic [31:0] l_din;
    logic [7:0]  l_dout;
    logic [1:0]  l_idx;

    logic        g_flush, g_vin, g_rin, g_vout, g_rout, g_last;
    logic [47:0] g_din;
    logic [15:0] g_dout;
    logic [1:0]  g_idx;

    int n_cmp;
    int n_err;

    conv_wide_narrow_hs #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .flush(m_flush), .data_in(m_din), .valid_in(m_vin),
        .ready_in(m_rin), .data_out(m_dout), .valid_out(m_vout), .ready_out(m_rout),
        .lane_idx(m_idx), .last_out(m_last)
    );

    conv_wide_narrow_hs #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .flush(l_flush), .data_in(l_din), .valid_in(l_vin),
        .ready_in(l_rin), .data_out(l_dout), .valid_out(l_vout), .ready_out(l_rout),
        .lane_idx(l_idx), .last_out(l_last)
    );

    conv_wide_narrow_hs #(.IN_W(48), .OUT_W(16), .MSB_FIRST(1'b1)) dut_g (
        .clk(clk), .reset(reset), .flush(g_flush), .data_in(g_din), .valid_in(g_vin),
        .ready_in(g_rin), .data_out(g_dout), .valid_out(g_vout), .ready_out(g_rout),
        .lane_idx(g_idx), .last_out(g_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_m(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] idx, input logic last, input logic rin);
        chk({tag, ".valid_out"}, 64'(m_vout), 64'(v));
        chk({tag, ".data_out"},  64'(m_dout), 64'(d));
        chk({tag, ".lane_idx"},  64'(m_idx),  64'(idx));
        chk({tag, ".last_out"},  64'(m_last), 64'(last));
        chk({tag, ".ready_in"},  64'(m_rin),  64'(rin));
    endtask

    task automatic chk_l(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] idx, input logic last, input logic rin);
        chk({tag, ".valid_out"}, 64'(l_vout), 64'(v));
        chk({tag, ".data_out"},  64'(l_dout), 64'(d));
        chk({tag, ".lane_idx"},  64'(l_idx),  64'(idx));
        chk({tag, ".last_out"},  64'(l_last), 64'(last));
        chk({tag, ".ready_in"},  64'(l_rin),  64'(rin));
    endtask

    task automatic chk_g(input string tag, input logic v, input logic [15:0] d,
                         input logic [1:0] idx, input logic last, input logic rin);
        chk({tag, ".valid_out"}, 64'(g_vout), 64'(v));
        chk({tag, ".data_out"},  64'(g_dout), 64'(d));
        chk({tag, ".lane_idx"},  64'(g_idx),  64'(idx));
        chk({tag, ".last_out"},  64'(g_last), 64'(last));
        chk({tag, ".ready_in"},  64'(g_rin),  64'(rin));
    endtask

    // Step to just after the next rising edge; inputs are driven there and
    // outputs are checked 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        m_flush = 1'b0; m_vin = 1'b0; m_din = '0; m_rout = 1'b1;
        l_flush = 1'b0; l_vin = 1'b0; l_din = '0; l_rout = 1'b1;
        g_flush = 1'b0; g_vin = 1'b0; g_din = '0; g_rout = 1'b1;

        // Reset state
        cyc(); cyc();
        #1 chk_m("rst_m", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        chk_l("rst_l", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        chk_g("rst_g", 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);

        // MSB-first lane order
        cyc(); reset = 1'b0; m_vin = 1'b1; m_din = 32'hA1B2C3D4;
        #1 chk_m("msb_offer", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        cyc(); m_vin = 1'b0;
        #1 chk_m("msb_l0", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_m("msb_l1", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_m("msb_l2", 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_m("msb_l3", 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1);
        cyc(); #1 chk_m("msb_idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

        // Back-to-back LSB-first words, no bubble
        l_vin = 1'b1; l_din = 32'h11223344;
        #1 chk_l("b2b_offer", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        cyc(); l_din = 32'h55667788;
        #1 chk_l("b2b_w0l0", 1'b1, 8'h44, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_l("b2b_w0l1", 1'b1, 8'h33, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_l("b2b_w0l2", 1'b1, 8'h22, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_l("b2b_w0l3", 1'b1, 8'h11, 2'd3, 1'b1, 1'b1);
        cyc(); l_vin = 1'b0; l_din = 32'hFFFFFFFF;
        #1 chk_l("b2b_w1l0", 1'b1, 8'h88, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_l("b2b_w1l1", 1'b1, 8'h77, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_l("b2b_w1l2", 1'b1, 8'h66, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_l("b2b_w1l3", 1'b1, 8'h55, 2'd3, 1'b1, 1'b1);
        cyc(); #1 chk_l("b2b_idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

        // Backpressure on lane 1; data_in churn while busy must be ignored
        m_vin = 1'b1; m_din = 32'hA1B2C3D4;
        cyc(); m_vin = 1'b0;
        #1 chk_m("bp_l0", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
        cyc(); m_rout = 1'b0; m_vin = 1'b1; m_din = 32'hFFFFFFFF;
        #1 chk_m("bp_hold0", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); m_din = 32'h00000000;
        #1 chk_m("bp_hold1", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); m_din = 32'h5A5A5A5A;
        #1 chk_m("bp_hold2", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); m_rout = 1'b1; m_vin = 1'b0;
        #1 chk_m("bp_hold3", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_m("bp_l2", 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_m("bp_l3", 1'b1, 8'hD4, 2'd3, 1'b1, 1'b1);
        cyc(); #1 chk_m("bp_idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

        // Flush during lane 2, with a word offered on the flush edge
        m_vin = 1'b1; m_din = 32'hA1B2C3D4;
        cyc(); m_vin = 1'b0;
        #1 chk_m("fl_l0", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_m("fl_l1", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); m_flush = 1'b1; m_vin = 1'b1; m_din = 32'hDEADBEEF;
        #1 chk_m("fl_l2", 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
        cyc(); m_flush = 1'b0;
        #1 chk_m("fl_after", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        cyc(); m_vin = 1'b0;
        #1 chk_m("fl_new_l0", 1'b1, 8'hDE, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_m("fl_new_l1", 1'b1, 8'hAD, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_m("fl_new_l2", 1'b1, 8'hBE, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_m("fl_new_l3", 1'b1, 8'hEF, 2'd3, 1'b1, 1'b1);
        cyc(); #1 chk_m("fl_idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

        // Reset for two cycles during lane 2
        m_vin = 1'b1; m_din = 32'hA1B2C3D4;
        cyc(); m_vin = 1'b0;
        #1 chk_m("rm_l0", 1'b1, 8'hA1, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_m("rm_l1", 1'b1, 8'hB2, 2'd1, 1'b0, 1'b0);
        cyc(); reset = 1'b1;
        #1 chk_m("rm_l2", 1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_m("rm_in_reset", 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        cyc(); reset = 1'b0; m_vin = 1'b1; m_din = 32'h0F1E2D3C;
        #1 chk_m("rm_release", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        cyc(); m_vin = 1'b0;
        #1 chk_m("rm_new_l0", 1'b1, 8'h0F, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_m("rm_new_l1", 1'b1, 8'h1E, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_m("rm_new_l2", 1'b1, 8'h2D, 2'd2, 1'b0, 1'b0);
        cyc(); #1 chk_m("rm_new_l3", 1'b1, 8'h3C, 2'd3, 1'b1, 1'b1);
        cyc(); #1 chk_m("rm_idle", 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

        // 48-bit word into 16-bit lanes
        g_vin = 1'b1; g_din = 48'h123456789ABC;
        #1 chk_g("gen_offer", 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1);
        cyc(); g_vin = 1'b0;
        #1 chk_g("gen_l0", 1'b1, 16'h1234, 2'd0, 1'b0, 1'b0);
        cyc(); #1 chk_g("gen_l1", 1'b1, 16'h5678, 2'd1, 1'b0, 1'b0);
        cyc(); #1 chk_g("gen_l2", 1'b1, 16'h9ABC, 2'd2, 1'b1, 1'b1);
        cyc(); #1 chk_g("gen_idle", 1'b0, 16'h0000, 2'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
